// File: rtl/noise_stim_ctrl.sv
// rtl/noise_stim_ctrl.sv - LFSR noise stimulus sequencer feeding the FIR input handshake
// Paces LFSR steps, sweeps amplitude levels in bursts and hands samples over valid/ready.
module noise_stim_ctrl #(
    parameter int LFSR_WIDTH = 24,
    parameter int DIV_W      = 16,
    parameter int CNT_W      = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic                  i_loop,
    input  logic [DIV_W-1:0]      i_div,
    input  logic [CNT_W-1:0]      i_burst_len,
    input  logic [1:0]            i_sel_start,
    input  logic [LFSR_WIDTH-1:0] i_noise,
    output logic                  o_lfsr_en,
    output logic [1:0]            o_lfsr_sel,
    output logic [LFSR_WIDTH-1:0] o_sample,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overrun
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                  state_q;
    logic [DIV_W-1:0]        div_q;
    logic [DIV_W-1:0]        div_cnt_q;
    logic [CNT_W-1:0]        burst_q;
    logic [CNT_W-1:0]        burst_cnt_q;
    logic [1:0]              sel_start_q;
    logic [1:0]              sel_q;
    logic                    loop_q;
    logic [LFSR_WIDTH-1:0]   sample_q;
    logic                    valid_q;
    logic                    overrun_q;
    logic                    busy_q;
    logic                    done_q;

    logic                    div_wrap;
    logic                    tick;
    logic                    slot_free;
    logic                    capture;
    logic                    drop;
    logic                    burst_end;
    logic [DIV_W-1:0]        div_cnt_d;
    logic [CNT_W-1:0]        burst_cnt_d;

    // Abort gates the tick so the LFSR never steps in the abort cycle.
    always_comb begin
        div_wrap    = (div_cnt_q == div_q);
        div_cnt_d   = div_cnt_q + DIV_W'(1);
        burst_cnt_d = burst_cnt_q + CNT_W'(1);
        tick        = (state_q == S_RUN) && div_wrap && !i_abort;
        slot_free   = !valid_q || i_ready;
        capture     = tick && slot_free;
        drop        = tick && !slot_free;
        burst_end   = (burst_cnt_d == burst_q);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            div_cnt_q   <= '0;
            burst_q     <= '0;
            burst_cnt_q <= '0;
            sel_start_q <= '0;
            sel_q       <= '0;
            loop_q      <= 1'b0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (i_abort) begin
                state_q <= S_IDLE;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (i_start) begin
                            state_q     <= S_RUN;
                            busy_q      <= 1'b1;
                            div_q       <= i_div;
                            // A zero burst length behaves as one sample per level.
                            burst_q     <= (i_burst_len == '0) ? CNT_W'(1) : i_burst_len;
                            sel_start_q <= i_sel_start;
                            loop_q      <= i_loop;
                            sel_q       <= i_sel_start;
                            div_cnt_q   <= '0;
                            burst_cnt_q <= '0;
                            overrun_q   <= 1'b0;
                        end
                    end
                    S_RUN: begin
                        div_cnt_q <= div_wrap ? '0 : div_cnt_d;
                        if (capture) begin
                            sample_q <= i_noise;
                            valid_q  <= 1'b1;
                            if (burst_end) begin
                                burst_cnt_q <= '0;
                                if (sel_q != 2'd3) begin
                                    sel_q <= sel_q + 2'd1;
                                end else if (loop_q) begin
                                    sel_q <= sel_start_q;
                                end else begin
                                    state_q <= S_DRAIN;
                                end
                            end else begin
                                burst_cnt_q <= burst_cnt_d;
                            end
                        end else if (i_ready) begin
                            valid_q <= 1'b0;
                        end
                        if (drop) begin
                            overrun_q <= 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        if (i_ready) begin
                            valid_q <= 1'b0;
                        end
                        if (slot_free) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_lfsr_en  = capture;
    assign o_lfsr_sel = sel_q;
    assign o_sample   = sample_q;
    assign o_valid    = valid_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_noise_stim_ctrl.sv
// tb/tb_noise_stim_ctrl.sv - self-checking bench for noise_stim_ctrl
module tb_noise_stim_ctrl;
    localparam int LW = 24;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic          i_loop = 1'b0;
    logic [15:0]   i_div = '0;
    logic [11:0]   i_burst_len = '0;
    logic [1:0]    i_sel_start = '0;
    logic [LW-1:0] i_noise = '0;
    logic          i_ready = 1'b1;
    logic          o_lfsr_en;
    logic [1:0]    o_lfsr_sel;
    logic [LW-1:0] o_sample;
    logic          o_valid;
    logic          o_busy;
    logic          o_done;
    logic          o_overrun;

    always #5 i_clk = ~i_clk;

    noise_stim_ctrl #(.LFSR_WIDTH(LW), .DIV_W(16), .CNT_W(12)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
        .i_loop(i_loop), .i_div(i_div), .i_burst_len(i_burst_len),
        .i_sel_start(i_sel_start), .i_noise(i_noise), .o_lfsr_en(o_lfsr_en),
        .o_lfsr_sel(o_lfsr_sel), .o_sample(o_sample), .o_valid(o_valid),
        .i_ready(i_ready), .o_busy(o_busy), .o_done(o_done), .o_overrun(o_overrun)
    );

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: phase 0 idle, 1 run, 2 drain, 3 done.
    int            m_phase, m_cyc, m_ncap, m_total;
    bit            m_pend, m_ovr;
    logic [LW-1:0] m_sample;
    logic [1:0]    m_sel;
    int            cfg_div, cfg_beff, cfg_ss;
    bit            cfg_loop;

    int         cyc = 0;
    int         start_cyc, first_valid, done_cnt, accept_cnt;
    bit         busy_at_done;
    int         cap_cyc[$];
    logic [1:0] cap_sel[$];

    typedef struct {
        int          div;
        int          blen;
        int          ss;
        int          exp_n;
        int          exp_lat;
        logic [31:0] exp_sels;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] level_of(input int n);
        int idx;
        idx = n / cfg_beff;
        if (cfg_loop) return 2'(cfg_ss + idx % (4 - cfg_ss));
        return 2'((cfg_ss + idx > 3) ? 3 : cfg_ss + idx);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_cyc = 0; m_ncap = 0; m_total = 0;
        m_pend = 0; m_ovr = 0; m_sample = '0; m_sel = '0;
        cfg_div = 0; cfg_beff = 1; cfg_ss = 0; cfg_loop = 0;
    endtask

    task automatic clear_meas();
        first_valid = -1; done_cnt = 0; accept_cnt = 0; busy_at_done = 1'b1;
        cap_cyc.delete(); cap_sel.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_lfsr_en"}, 32'(o_lfsr_en), 32'd0);
        chk({tag, "_sel"}, 32'(o_lfsr_sel), 32'd0);
        chk({tag, "_sample"}, 32'(o_sample), 32'd0);
        chk({tag, "_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_done"}, 32'(o_done), 32'd0);
        chk({tag, "_overrun"}, 32'(o_overrun), 32'd0);
    endtask

    // Called at a falling edge with inputs applied; compares, advances model, waits for next falling edge.
    task automatic run_cycle();
        bit is_tick, slot, exp_en;
        i_noise = LW'($urandom);
        #1;
        is_tick = (m_phase == 1) && ((m_cyc % (cfg_div + 1)) == cfg_div);
        slot    = !m_pend || i_ready;
        exp_en  = is_tick && slot && !i_abort;
        chk("lfsr_en", 32'(o_lfsr_en), 32'(exp_en));
        chk("valid", 32'(o_valid), 32'(m_pend));
        chk("sample", 32'(o_sample), 32'(m_sample));
        chk("sel", 32'(o_lfsr_sel), 32'(m_sel));
        chk("busy", 32'(o_busy), 32'(m_phase == 1 || m_phase == 2));
        chk("done", 32'(o_done), 32'(m_phase == 3));
        chk("overrun", 32'(o_overrun), 32'(m_ovr));
        if (o_valid && first_valid < 0) first_valid = cyc - start_cyc;
        if (o_valid && i_ready) accept_cnt++;
        if (o_lfsr_en) begin
            cap_cyc.push_back(cyc);
            cap_sel.push_back(o_lfsr_sel);
        end
        if (o_done) begin
            done_cnt++;
            busy_at_done = o_busy;
        end
        if (i_abort) begin
            m_phase = 0;
            m_pend  = 0;
        end else begin
            case (m_phase)
                0: if (i_start) begin
                    cfg_div  = int'(i_div);
                    cfg_beff = (i_burst_len == 0) ? 1 : int'(i_burst_len);
                    cfg_ss   = int'(i_sel_start);
                    cfg_loop = i_loop;
                    m_total  = cfg_beff * (4 - cfg_ss);
                    m_phase = 1; m_cyc = 0; m_ncap = 0; m_ovr = 0;
                    m_sel = i_sel_start;
                    start_cyc = cyc;
                end
                1: begin
                    if (exp_en) begin
                        m_sample = i_noise;
                        m_pend   = 1;
                        m_ncap++;
                        m_sel = level_of(m_ncap);
                        if (!cfg_loop && m_ncap == m_total) m_phase = 2;
                    end else if (i_ready) begin
                        m_pend = 0;
                    end
                    if (is_tick && !slot) m_ovr = 1;
                    m_cyc++;
                end
                2: if (slot) begin
                    m_pend  = 0;
                    m_phase = 3;
                end
                default: m_phase = 0;
            endcase
        end
        cyc++;
        @(negedge i_clk);
    endtask

    task automatic start_sweep(input int div, input int blen, input int ss, input bit lp);
        i_div = 16'(div); i_burst_len = 12'(blen); i_sel_start = 2'(ss); i_loop = lp;
        clear_meas();
        i_start = 1'b1;
        run_cycle();
        i_start = 1'b0;
    endtask

    task automatic run_until_idle(input int budget, input bit rand_ready, input int abort_at);
        int c;
        for (c = 0; c < budget; c++) begin
            if (rand_ready) i_ready = ($urandom_range(0, 3) != 0);
            if (c == abort_at) i_abort = 1'b1;
            run_cycle();
            i_abort = 1'b0;
            if (!o_busy) break;
        end
        chk("sweep_ends", 32'(c < budget), 32'd1);
        run_cycle();
        run_cycle();
    endtask

    function automatic logic [31:0] packed_sels();
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < cap_sel.size() && k < 16; k++) s |= 32'(cap_sel[k]) << (2 * k);
        return s;
    endfunction

    initial begin
        logic [LW-1:0] held;
        int n_before, lvl0, bad_gaps;

        vecs[0] = '{div: 3, blen: 2, ss: 0, exp_n: 8, exp_lat: 5, exp_sels: 32'h0000_FA50};
        vecs[1] = '{div: 0, blen: 0, ss: 0, exp_n: 4, exp_lat: 2, exp_sels: 32'h0000_00E4};
        vecs[2] = '{div: 1, blen: 1, ss: 3, exp_n: 1, exp_lat: 3, exp_sels: 32'h0000_0003};
        vecs[3] = '{div: 2, blen: 3, ss: 2, exp_n: 6, exp_lat: 4, exp_sels: 32'h0000_0FEA};

        model_reset();
        clear_meas();
        i_rst = 1'b1;
        @(negedge i_clk);
        #1;
        chk_zero("reset");
        @(negedge i_clk);
        i_rst = 1'b0;

        // start and abort together in IDLE: abort wins
        i_div = 16'd0; i_burst_len = 12'd1; i_sel_start = 2'd1;
        i_start = 1'b1; i_abort = 1'b1;
        run_cycle();
        i_start = 1'b0; i_abort = 1'b0;
        run_cycle();
        chk("start_abort_busy", 32'(o_busy), 32'd0);
        chk("start_abort_sel", 32'(o_lfsr_sel), 32'd0);

        // table-driven single sweeps with the sink always ready
        i_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            start_sweep(vecs[v].div, vecs[v].blen, vecs[v].ss, 1'b0);
            run_until_idle(400, 1'b0, -1);
            bad_gaps = 0;
            for (int k = 1; k < cap_cyc.size(); k++)
                if (cap_cyc[k] - cap_cyc[k-1] != vecs[v].div + 1) bad_gaps++;
            chk("tbl_ncap", 32'(cap_cyc.size()), 32'(vecs[v].exp_n));
            chk("tbl_first_valid", 32'(first_valid), 32'(vecs[v].exp_lat));
            chk("tbl_gaps", 32'(bad_gaps), 32'd0);
            chk("tbl_sels", packed_sels(), vecs[v].exp_sels);
            chk("tbl_done_cnt", 32'(done_cnt), 32'd1);
            chk("tbl_busy_at_done", 32'(busy_at_done), 32'd0);
        end

        // backpressure: three stalled ticks at level 0
        i_ready = 1'b0;
        start_sweep(0, 4, 0, 1'b0);
        run_cycle();
        held = o_sample;
        n_before = cap_cyc.size();
        run_cycle(); run_cycle(); run_cycle();
        chk("bp_no_en", 32'(cap_cyc.size() - n_before), 32'd0);
        chk("bp_sample_held", 32'(o_sample), 32'(held));
        chk("bp_overrun", 32'(o_overrun), 32'd1);
        i_ready = 1'b1;
        run_until_idle(400, 1'b0, -1);
        lvl0 = 0;
        foreach (cap_sel[k]) if (cap_sel[k] == 2'd0) lvl0++;
        chk("bp_level0_caps", 32'(lvl0), 32'd4);
        chk("bp_total_caps", 32'(cap_cyc.size()), 32'd16);
        chk("bp_accepts", 32'(accept_cnt), 32'd16);
        chk("bp_overrun_sticky", 32'(o_overrun), 32'd1);

        // fresh start clears overrun; a start while running is ignored
        start_sweep(1, 1, 3, 1'b0);
        chk("restart_overrun_clr", 32'(o_overrun), 32'd0);
        i_div = 16'd0; i_burst_len = 12'd5; i_sel_start = 2'd0;
        i_start = 1'b1;
        run_cycle();
        i_start = 1'b0;
        run_until_idle(400, 1'b0, -1);
        chk("ign_start_ncap", 32'(cap_cyc.size()), 32'd1);
        chk("ign_start_sels", packed_sels(), 32'h3);
        chk("ign_start_lat", 32'(first_valid), 32'd3);
        chk("ign_start_done", 32'(done_cnt), 32'd1);

        // loop wrap, aborted where the fifth capture would be
        start_sweep(0, 1, 2, 1'b1);
        for (int c = 0; c < 50 && cap_cyc.size() < 4; c++) run_cycle();
        i_abort = 1'b1;
        run_cycle();
        i_abort = 1'b0;
        chk("loop_abort_busy", 32'(o_busy), 32'd0);
        chk("loop_abort_valid", 32'(o_valid), 32'd0);
        run_cycle(); run_cycle(); run_cycle();
        chk("loop_ncap", 32'(cap_cyc.size()), 32'd4);
        chk("loop_sels", packed_sels(), 32'h0000_00EE);
        chk("loop_no_done", 32'(done_cnt), 32'd0);
        chk("loop_sel_held", 32'(o_lfsr_sel), 32'd2);

        // asynchronous reset in the middle of a sweep
        start_sweep(2, 2, 1, 1'b0);
        for (int c = 0; c < 6; c++) run_cycle();
        i_rst = 1'b1;
        #1;
        chk_zero("rst_mid");
        model_reset();
        @(negedge i_clk);
        i_rst = 1'b0;

        // randomized sweeps against the reference model
        for (int r = 0; r < 40; r++) begin
            int dv, bl, ss, ab;
            bit lp;
            dv = $urandom_range(0, 3);
            bl = $urandom_range(0, 3);
            ss = $urandom_range(0, 3);
            lp = ($urandom_range(0, 3) == 0);
            ab = lp ? $urandom_range(5, 60) : (($urandom_range(0, 4) == 0) ? $urandom_range(0, 30) : -1);
            for (int c = 0; c < $urandom_range(0, 3); c++) run_cycle();
            start_sweep(dv, bl, ss, lp);
            run_until_idle(3000, 1'b1, ab);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
